// File: rtl/instr_encoder_loader_pkg.sv
// Shared encoding constants, request op enum and loader FSM states
// for the MIPS instruction encoder/loader.
package instr_enc_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_ADDU  = 5'd1,
        OP_SUB   = 5'd2,
        OP_SUBU  = 5'd3,
        OP_AND   = 5'd4,
        OP_OR    = 5'd5,
        OP_NOR   = 5'd6,
        OP_SLTU  = 5'd7,
        OP_SLL   = 5'd8,
        OP_SRL   = 5'd9,
        OP_ADDIU = 5'd10,
        OP_ANDI  = 5'd11,
        OP_ORI   = 5'd12,
        OP_BEQ   = 5'd13,
        OP_LW    = 5'd14,
        OP_SW    = 5'd15,
        OP_J     = 5'd16
    } op_e;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_J     = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational encoding table: symbolic op plus fields to a 32-bit
// MIPS word; legal_o drops for selectors outside the supported set.
module instr_field_pack
    import instr_enc_pkg::*;
(
    input  logic [4:0]  op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [25:0] imm_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    logic [5:0] funct;
    logic [5:0] opc;
    logic       is_r;
    logic       is_i;
    logic       is_j;
    logic       is_sh;

    always_comb begin
        funct = FN_ADD;
        opc   = OPC_RTYPE;
        is_r  = 1'b0;
        is_i  = 1'b0;
        is_j  = 1'b0;
        is_sh = 1'b0;
        case (op_i)
            OP_ADD:   begin is_r = 1'b1; funct = FN_ADD;  end
            OP_ADDU:  begin is_r = 1'b1; funct = FN_ADDU; end
            OP_SUB:   begin is_r = 1'b1; funct = FN_SUB;  end
            OP_SUBU:  begin is_r = 1'b1; funct = FN_SUBU; end
            OP_AND:   begin is_r = 1'b1; funct = FN_AND;  end
            OP_OR:    begin is_r = 1'b1; funct = FN_OR;   end
            OP_NOR:   begin is_r = 1'b1; funct = FN_NOR;  end
            OP_SLTU:  begin is_r = 1'b1; funct = FN_SLTU; end
            OP_SLL:   begin is_r = 1'b1; is_sh = 1'b1; funct = FN_SLL; end
            OP_SRL:   begin is_r = 1'b1; is_sh = 1'b1; funct = FN_SRL; end
            OP_ADDIU: begin is_i = 1'b1; opc = OPC_ADDIU; end
            OP_ANDI:  begin is_i = 1'b1; opc = OPC_ANDI;  end
            OP_ORI:   begin is_i = 1'b1; opc = OPC_ORI;   end
            OP_BEQ:   begin is_i = 1'b1; opc = OPC_BEQ;   end
            OP_LW:    begin is_i = 1'b1; opc = OPC_LW;    end
            OP_SW:    begin is_i = 1'b1; opc = OPC_SW;    end
            OP_J:     begin is_j = 1'b1; end
            default:  ;
        endcase
    end

    // Shifts take their source from rt, so rs is zeroed; others zero shamt.
    always_comb begin
        word_o = '0;
        if (is_r) begin
            word_o = {OPC_RTYPE,
                      is_sh ? 5'd0 : rs_i,
                      rt_i, rd_i,
                      is_sh ? shamt_i : 5'd0,
                      funct};
        end else if (is_i) begin
            word_o = {opc, rs_i, rt_i, imm_i[15:0]};
        end else if (is_j) begin
            word_o = {OPC_J, imm_i};
        end
    end

    assign legal_o = is_r | is_i | is_j;

endmodule

// File: rtl/instr_encoder_loader.sv
// Session FSM and one-stage output register streaming encoded words
// with sequential addresses into the instruction-memory write port.
module instr_encoder_loader
    import instr_enc_pkg::*;
#(
    parameter int AW = 10,
    parameter int LW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [LW-1:0] length,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_op,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_shamt,
    input  logic [25:0]   in_imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_word,
    output logic [AW-1:0] out_addr,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [LW-1:0] acc_q, acc_d;
    logic [LW-1:0] len_q, len_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          ov_q, ov_d;
    logic [31:0]   ow_q, ow_d;

    logic [31:0]   enc_word;
    logic          enc_legal;
    logic          in_fire;
    logic          out_fire;

    instr_field_pack u_pack (
        .op_i    (in_op),
        .rs_i    (in_rs),
        .rt_i    (in_rt),
        .rd_i    (in_rd),
        .shamt_i (in_shamt),
        .imm_i   (in_imm),
        .word_o  (enc_word),
        .legal_o (enc_legal)
    );

    // acc_q counts legal accepts so the bench side can never over-fill.
    assign in_ready = (state_q == ST_LOAD) && (!ov_q || out_ready)
                      && (acc_q < len_q);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = ov_q && out_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        len_d   = len_q;
        done_d  = done_q;
        err_d   = err_q;
        ov_d    = ov_q;
        ow_d    = ow_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    addr_d = base_addr;
                    rem_d  = length;
                    len_d  = length;
                    acc_d  = '0;
                    err_d  = 1'b0;
                    ov_d   = 1'b0;
                    if (length == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                        done_d  = 1'b0;
                    end
                end
            end
            ST_LOAD: begin
                if (out_fire) begin
                    ov_d   = 1'b0;
                    addr_d = addr_q + AW'(1);
                    rem_d  = rem_q - LW'(1);
                    if (rem_q == LW'(1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
                if (in_fire) begin
                    if (enc_legal) begin
                        ov_d  = 1'b1;
                        ow_d  = enc_word;
                        acc_d = acc_q + LW'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ov_q    <= 1'b0;
            ow_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            len_q   <= len_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ov_q    <= ov_d;
            ow_q    <= ow_d;
        end
    end

    assign out_valid = ov_q;
    assign out_word  = ow_q;
    assign out_addr  = addr_q;
    assign busy      = (state_q == ST_LOAD);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the single-cycle control decoder: takes symbolic instruction requests (operation selector plus register and immediate fields) and encodes them into 32-bit MIPS words.
- Supports exactly the opcode/funct set the decoder recognises.
- Streams the encoded words, with sequential word addresses, into the instruction-memory write port of the test/boot loader path.
- Runs a load session of a programmed length and reports done or error.

Parameters:
- AW, 10, instruction-memory word-address width.
- LW, 10, session length counter width.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a session, ignored while in LOAD.
- base_addr  in  AW  first word address of the session, sampled on start.
- length  in  LW  number of words in the session, sampled on start.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_op  in  5  operation selector (enum, see Decomposition).
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register fields.
- in_imm  in  26  immediate; low 16 bits for I-type, all 26 for j.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  memory accepts the word.
- out_word  out  32  encoded instruction.
- out_addr  out  AW  word address.
- busy  out  1  high in LOAD.
- done  out  1  session completed; held high until the next start.
- err  out  1  sticky illegal-op flag; cleared on start.

Behaviour:
- Reset: state IDLE. All of the following are 0: in_ready, out_valid, out_word, out_addr, busy, done, err, the address counter and the remaining-words counter.
- FSM states: IDLE, LOAD, DONE.
  - IDLE or DONE --start--> if length==0, go to DONE with done=1; otherwise go to LOAD, addr<=base_addr, remaining<=length, done<=0, err<=0.
  - LOAD --> DONE on the output handshake of the last word (remaining goes 1->0). done rises in the same cycle the state becomes DONE.
  - start while in LOAD is ignored.
- Output register: a single stage.
  - in_ready = (state==LOAD) && (!out_valid || out_ready) && (accepted_count < length).
  - Acceptance never exceeds length. A separate accepted counter or a pending flag prevents over-accept.
  - A legal request accepted at cycle N gives out_valid=1 with the word at cycle N+1, so latency is 1.
  - out_word and out_addr stay stable while out_valid && !out_ready.
  - Back-to-back throughput is 1 word/cycle when out_ready is held high.
- Address: increments by 1 per output handshake and wraps modulo 2^AW without error.
- Encoding:
  - R-type: opcode 000000, fields rs|rt|rd|shamt|funct.
    - funct values: add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, nor 100111, sltu 101011, sll 000000, srl 000010.
    - sll/srl force rs=0.
    - All other R ops force shamt=0.
  - I-type: opcode|rs|rt|imm[15:0].
    - opcode values: addiu 001001, andi 001100, ori 001101, beq 000100, lw 100011, sw 101011.
    - in_imm[25:16] is ignored.
  - J-type: j is 000010|imm[25:0]; rs/rt/rd are ignored.
- Illegal in_op (enum values 17..31):
  - The request is consumed (handshake completes).
  - No output word is produced; address and remaining are unchanged.
  - err<=1 sticky.
  - The session still needs length legal words to finish.
- rst mid-session: immediate return to IDLE, the pending out word is discarded, all outputs return to their reset values.

Decomposition:
- Package instr_enc_pkg holds:
  - the op enum: ADD, ADDU, SUB, SUBU, AND, OR, NOR, SLTU, SLL, SRL = 0..9; ADDIU, ANDI, ORI, BEQ, LW, SW, J = 10..16.
  - 6-bit opcode and funct localparams shared with the decoder.
  - FSM state typedef.
- One combinational sub-module, instr_field_pack (op plus fields in; word and legal out), keeps the encoding table separate from the session FSM and handshake logic.

Test Plan:
- start base=0x3FE, length=3; requests add(1,2,3), lw(rs=4,rt=5,imm=0x0010), j(0x0000040) with out_ready=1 -> words 0x00221820 @0x3FE, 0x8C850010 @0x3FF, 0x08000040 @0x000 (wrap); done=1 after the third handshake.
- sll rs=7, rt=2, rd=9, shamt=4 -> 0x00024900 (rs forced 0); srl same fields -> 0x00024902.
- out_ready held 0 for 5 cycles after the first word -> out_word and out_addr stable, in_ready=0, no second accept; release -> next word within 1 cycle.
- Session length=2; in_op=20, then ori(rs=1,rt=2,imm=0xFFFF), then beq(rs=3,rt=4,imm=0x0002) -> err=1; only 0x3422FFFF and 0x10640002 are emitted; done=1.
- length=0 start -> done=1 next cycle, busy never asserts, in_ready=0.
- rst asserted while out_valid=1 mid-session -> next cycle out_valid=0, busy=0, done=0, state IDLE; a new start behaves normally.
